// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_compare_ctrl                                             |
// | Purpose  : Bit-serial word equality check using one external 1-bit         |
// |            comparator; reports eq and the lowest mismatching bit index.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int IDXW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic [IDXW-1:0]  mismatch_idx,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    eq_d      = eq_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cmp_x     = 1'b0;
    cmp_y     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy  = 1'b1;
        cmp_x = a_q[cnt_q];
        cmp_y = b_q[cnt_q];
        // eq_q still high means no earlier bit mismatched, so this is the lowest one
        if (!cmp_z && eq_q) begin
          eq_d  = 1'b0;
          idx_d = cnt_q;
        end
        if ((EARLY_EXIT && !cmp_z) || (cnt_q == C_LAST_IDX)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + IDXW'(1);
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign eq           = eq_q;
  assign mismatch_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_compare_ctrl                                          |
// | Purpose  : Bench for serial_compare_ctrl, early-exit and full-scan builds. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_compare_ctrl;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a, b;
  logic          out_ready;

  logic          in_ready0, in_ready1;
  logic          cmp_x0, cmp_y0, cmp_z0, cmp_x1, cmp_y1, cmp_z1;
  logic          out_valid0, out_valid1;
  logic          eq0, eq1;
  logic [IW-1:0] idx0, idx1;
  logic          busy0, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural single-bit comparators
  assign cmp_z0 = (cmp_x0 == cmp_y0);
  assign cmp_z1 = (cmp_x1 == cmp_y1);

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_early (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cmp_x(cmp_x0), .cmp_y(cmp_y0), .cmp_z(cmp_z0),
    .out_valid(out_valid0), .out_ready(out_ready), .eq(eq0),
    .mismatch_idx(idx0), .busy(busy0)
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cmp_x(cmp_x1), .cmp_y(cmp_y1), .cmp_z(cmp_z1),
    .out_valid(out_valid1), .out_ready(out_ready), .eq(eq1),
    .mismatch_idx(idx1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int first_mismatch(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < W; i++) begin
      if (x[i] != y[i]) return i;
    end
    return -1;
  endfunction

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input bit keep_valid);
    int            k;
    int            lat0, lat1;
    logic          exp_eq;
    logic [IW-1:0] exp_idx;
    logic          eb0, eb1, ex0, ey0, ex1, ey1;
    k       = first_mismatch(av, bv);
    exp_eq  = (k < 0);
    exp_idx = (k < 0) ? '0 : k[IW-1:0];
    lat1    = W + 1;
    lat0    = (k < 0) ? W + 1 : k + 2;

    in_valid = 1'b1;
    a        = av;
    b        = bv;
    chk("in_ready_idle_e", {63'd0, in_ready0}, 64'd1);
    chk("in_ready_idle_f", {63'd0, in_ready1}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = keep_valid;
    a        = W'($urandom);
    b        = W'($urandom);

    for (int c = 1; c <= W + 1 + hold; c++) begin
      @(negedge clk);
      eb0 = (c < lat0);
      eb1 = (c < lat1);
      ex0 = 1'b0; ey0 = 1'b0; ex1 = 1'b0; ey1 = 1'b0;
      if (eb0) begin ex0 = av[c-1]; ey0 = bv[c-1]; end
      if (eb1) begin ex1 = av[c-1]; ey1 = bv[c-1]; end
      chk("busy_e",      {63'd0, busy0},      {63'd0, eb0});
      chk("busy_f",      {63'd0, busy1},      {63'd0, eb1});
      chk("out_valid_e", {63'd0, out_valid0}, {63'd0, ~eb0});
      chk("out_valid_f", {63'd0, out_valid1}, {63'd0, ~eb1});
      chk("cmp_x_e",     {63'd0, cmp_x0},     {63'd0, ex0});
      chk("cmp_y_e",     {63'd0, cmp_y0},     {63'd0, ey0});
      chk("cmp_x_f",     {63'd0, cmp_x1},     {63'd0, ex1});
      chk("cmp_y_f",     {63'd0, cmp_y1},     {63'd0, ey1});
      chk("in_ready_run_e", {63'd0, in_ready0}, 64'd0);
      chk("in_ready_run_f", {63'd0, in_ready1}, 64'd0);
      if (!eb0) begin
        chk("eq_e",  {63'd0, eq0},  {63'd0, exp_eq});
        chk("idx_e", 64'(idx0),     64'(exp_idx));
      end
      if (!eb1) begin
        chk("eq_f",  {63'd0, eq1},  {63'd0, exp_eq});
        chk("idx_f", 64'(idx1),     64'(exp_idx));
      end
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_out_valid_e", {63'd0, out_valid0}, 64'd0);
    chk("post_hs_out_valid_f", {63'd0, out_valid1}, 64'd0);
    chk("post_hs_in_ready_e",  {63'd0, in_ready0},  64'd1);
    chk("post_hs_in_ready_f",  {63'd0, in_ready1},  64'd1);
    chk("post_hs_busy_e",      {63'd0, busy0},      64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready0},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_eq",        {63'd0, eq0},        64'd0);
    chk("rst_idx",       64'(idx0),           64'd0);
    chk("rst_busy",      {63'd0, busy0},      64'd0);
    chk("rst_cmp_x",     {63'd0, cmp_x0},     64'd0);
    chk("rst_cmp_y",     {63'd0, cmp_y0},     64'd0);

    run_op(8'hA5, 8'hA5, 0, 1'b0);
    run_op(8'hA5, 8'hA1, 5, 1'b1);
    run_op(8'h00, 8'h90, 2, 1'b0);

    // abort a scan in progress
    in_valid = 1'b1;
    a        = 8'hA5;
    b        = 8'hA5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run_busy", {63'd0, busy0}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_e",      {63'd0, busy0},      64'd0);
    chk("abort_busy_f",      {63'd0, busy1},      64'd0);
    chk("abort_in_ready_e",  {63'd0, in_ready0},  64'd1);
    chk("abort_in_ready_f",  {63'd0, in_ready1},  64'd1);
    chk("abort_out_valid_e", {63'd0, out_valid0}, 64'd0);
    chk("abort_out_valid_f", {63'd0, out_valid1}, 64'd0);
    run_op(8'hFF, 8'h7F, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
